// File: rtl/minrv32_pkg.sv
// minrv32_pkg: shared types and helpers for the minrv32 data-memory responder.
//   state_e        responder FSM states
//   MASK_B/H/W     legal byte-mask encodings for SB/LB, SH/LH, SW/LW
//   size_from_mask access size in bytes, 0 for an illegal pattern
package minrv32_pkg;

   typedef enum logic [2:0] {IDLE, WAIT, ACC0, ACC1, RESP} state_e;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   function automatic logic [2:0] size_from_mask(input logic [3:0] m);
      return m == MASK_B ? 3'd1 : m == MASK_H ? 3'd2 : m == MASK_W ? 3'd4 : 3'd0;
   endfunction

endpackage

// File: rtl/minrv32_bytemem.sv
// minrv32_bytemem: single-port word RAM with per-byte write enables, 1-cycle synchronous read.
//   clk      clock
//   addr_i   word index
//   we_i     per-lane write enables
//   wdata_i  write data, lane-organised
//   rdata_o  registered read data of the previously addressed word (old data on a write)
module minrv32_bytemem #(
   parameter  int DEPTH_WORDS = 1024,
   localparam int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic [AW-1:0] addr_i,
   input  logic [3:0]    we_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      rdata_o <= mem_q[addr_i];
   end

endmodule

// File: rtl/minrv32_dmem_responder.sv
// minrv32_dmem_responder: serves minrv32 mem_* loads/stores from a byte-enabled word RAM.
//   clk, resetn        clock, synchronous active-low reset
//   mem_valid          request present, held stable until mem_ready
//   mem_instr          unused
//   mem_addr           byte address of first byte
//   mem_wdata          LSB-justified store data
//   mem_wstrb/rmask    size mask for stores/loads
//   mem_ready          one-cycle completion pulse
//   mem_rdata          LSB-justified load data, zero outside a load completion
//   mem_fault          access rejected (qualifies mem_ready)
module minrv32_dmem_responder
   import minrv32_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   input  logic [3:0]  mem_rmask,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        mem_fault
);

   localparam int          AW    = $clog2(DEPTH_WORDS);
   localparam logic [32:0] LIMIT = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);

   state_e        state_q;
   logic [31:0]   addr_q, wdata_q;
   logic [3:0]    mask_q, cnt_q;
   logic          wr_q, flt_q, cross_q, ready_q, fault_q;
   logic [23:0]   hold_q;
   logic [3:0]    mask_d;
   logic [2:0]    n_d;
   logic [32:0]   last_d;
   logic          flt_d;
   logic [7:0]    lanes_d, lanes;
   logic [1:0]    o;
   logic [AW-1:0] widx;
   logic [3:0]    we;
   logic [31:0]   wrot, dout, rsh, bmask;
   logic          unused;

   assign unused = mem_instr;

   // Request decode, only consumed in IDLE when the request is captured.
   always_comb begin
      mask_d  = mem_wstrb != 4'd0 ? mem_wstrb : mem_rmask;
      n_d     = size_from_mask(mask_d);
      last_d  = {1'b0, mem_addr} + 33'(n_d) - 33'd1;
      flt_d   = (mem_wstrb != 4'd0 && mem_rmask != 4'd0) ||
                (mask_d != 4'd0 && (n_d == 3'd0 || mem_addr < ADDR_BASE || last_d >= LIMIT));
      lanes_d = 8'(mask_d) << mem_addr[1:0];
   end

   // Lane set spans two words: [3:0] first word, [7:4] the following word.
   assign o     = addr_q[1:0];
   assign lanes = 8'(mask_q) << o;
   assign widx  = AW'((addr_q - ADDR_BASE) >> 2) + AW'(state_q == ACC1);
   // Writes stop as soon as the core withdraws the request.
   assign we    = (state_q == ACC0 ? lanes[3:0] : state_q == ACC1 ? lanes[7:4] : 4'd0) &
                  {4{wr_q & ~flt_q & mem_valid}};
   // Rotating the store data by o bytes puts core byte i on lane (o+i)&3 for both words.
   assign wrot  = 32'({wdata_q, wdata_q} >> (6'd32 - {1'b0, o, 3'b000}));

   minrv32_bytemem #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
      .clk     (clk),
      .addr_i  (widx),
      .we_i    (we),
      .wdata_i (wrot),
      .rdata_o (dout)
   );

   // Crossing loads: lanes 1..3 of the first word sit in hold_q beneath the second word.
   assign bmask     = {{8{mask_q[3]}}, {8{mask_q[2]}}, {8{mask_q[1]}}, {8{mask_q[0]}}};
   assign rsh       = 32'((cross_q ? {dout, hold_q, 8'h00} : {32'h0, dout}) >> {o, 3'b000});
   // Driven purely from flops, so no input-to-output path.
   assign mem_rdata = ready_q & ~fault_q & ~wr_q ? rsh & bmask : 32'h0;
   assign mem_ready = ready_q;
   assign mem_fault = fault_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         ready_q <= 1'b0;
         fault_q <= 1'b0;
         hold_q  <= 24'h0;
      end else begin
         ready_q <= 1'b0;
         fault_q <= 1'b0;
         case (state_q)
            IDLE: if (mem_valid) begin
               addr_q  <= mem_addr;
               wdata_q <= mem_wdata;
               mask_q  <= mask_d;
               wr_q    <= mem_wstrb != 4'd0;
               flt_q   <= flt_d;
               cross_q <= lanes_d[7:4] != 4'd0 && !flt_d;
               cnt_q   <= 4'(WAIT_STATES - 1);
               state_q <= WAIT_STATES > 0 ? WAIT : ACC0;
            end
            WAIT: begin
               state_q <= !mem_valid ? IDLE : cnt_q == 4'd0 ? ACC0 : WAIT;
               cnt_q   <= cnt_q - 4'd1;
            end
            ACC0: if (!mem_valid) state_q <= IDLE;
            else if (cross_q) state_q <= ACC1;
            else begin
               state_q <= RESP;
               ready_q <= 1'b1;
               fault_q <= flt_q;
            end
            ACC1: if (!mem_valid) state_q <= IDLE;
            else begin
               hold_q  <= dout[31:8];
               state_q <= RESP;
               ready_q <= 1'b1;
               fault_q <= flt_q;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_minrv32_dmem_responder.sv
// tb_minrv32_dmem_responder: directed-vector bench for the data-memory responder.
module tb_minrv32_dmem_responder;
   import minrv32_pkg::*;

   logic        clk = 1'b0, resetn = 1'b0;
   logic        v0 = 1'b0, v3 = 1'b0, instr = 1'b0;
   logic [31:0] addr = 32'h0, wdata = 32'h0;
   logic [3:0]  wstrb = 4'h0, rmask = 4'h0;
   logic        rdy0, rdy3, flt0, flt3;
   logic [31:0] rd0, rd3;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   minrv32_dmem_responder #(.ADDR_BASE(32'h0), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut (
      .clk(clk), .resetn(resetn), .mem_valid(v0), .mem_instr(instr), .mem_addr(addr),
      .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_rmask(rmask),
      .mem_ready(rdy0), .mem_rdata(rd0), .mem_fault(flt0));

   minrv32_dmem_responder #(.ADDR_BASE(32'h100), .DEPTH_WORDS(16), .WAIT_STATES(3)) u_dut3 (
      .clk(clk), .resetn(resetn), .mem_valid(v3), .mem_instr(instr), .mem_addr(addr),
      .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_rmask(rmask),
      .mem_ready(rdy3), .mem_rdata(rd3), .mem_fault(flt3));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issue one request (called #1 after a posedge), wait for ready, then idle one cycle.
   task automatic tx(input bit w3, input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] ws, input logic [3:0] rm,
                     input logic [31:0] exp_rd, input logic exp_f, input int exp_lat);
      bit got;
      int lat;
      addr = a; wdata = d; wstrb = ws; rmask = rm;
      if (w3) v3 = 1'b1; else v0 = 1'b1;
      got = 1'b0;
      lat = 0;
      while (!got && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         got = w3 ? rdy3 : rdy0;
      end
      chk({tag, "_ready"}, 32'(got), 32'd1);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_fault"}, 32'(w3 ? flt3 : flt0), 32'(exp_f));
      if (!(ws != 4'h0 && rm == 4'h0)) chk({tag, "_rdata"}, w3 ? rd3 : rd0, exp_rd);
      v0 = 1'b0; v3 = 1'b0; wstrb = 4'h0; rmask = 4'h0;
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int pulses;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(rdy0), 32'd0);
      chk("rst_fault", 32'(flt0), 32'd0);
      chk("rst_rdata", rd0, 32'h0);
      chk("rst_ready3", 32'(rdy3), 32'd0);
      resetn = 1'b1;
      @(posedge clk); #1;

      // Aligned word and byte-lane steering, no wait states
      tx(0, "sw10",   32'h10, 32'hDEADBEEF, 4'hF, 4'h0, 32'h0,        1'b0, 2);
      tx(0, "lw10",   32'h10, 32'h0,        4'h0, 4'hF, 32'hDEADBEEF, 1'b0, 2);
      tx(0, "sw10b",  32'h10, 32'h11223344, 4'hF, 4'h0, 32'h0,        1'b0, 2);
      tx(0, "sb13",   32'h13, 32'h000000A5, 4'h1, 4'h0, 32'h0,        1'b0, 2);
      tx(0, "lbu13",  32'h13, 32'h0,        4'h0, 4'h1, 32'h000000A5, 1'b0, 2);
      tx(0, "lw10c",  32'h10, 32'h0,        4'h0, 4'hF, 32'hA5223344, 1'b0, 2);

      // Word-crossing accesses
      tx(0, "sw14",   32'h14, 32'h0,        4'hF, 4'h0, 32'h0,        1'b0, 2);
      tx(0, "sw18",   32'h18, 32'h0,        4'hF, 4'h0, 32'h0,        1'b0, 2);
      tx(0, "sw16",   32'h16, 32'h87654321, 4'hF, 4'h0, 32'h0,        1'b0, 3);
      tx(0, "lw14",   32'h14, 32'h0,        4'h0, 4'hF, 32'h43210000, 1'b0, 2);
      tx(0, "lw18",   32'h18, 32'h0,        4'h0, 4'hF, 32'h00008765, 1'b0, 2);
      tx(0, "lw16",   32'h16, 32'h0,        4'h0, 4'hF, 32'h87654321, 1'b0, 3);
      tx(0, "lh17",   32'h17, 32'h0,        4'h0, 4'h3, 32'h00006543, 1'b0, 3);

      // Range edge, faults and empty request
      tx(0, "sw0",    32'h0,    32'hCAFEF00D, 4'hF, 4'h0, 32'h0,        1'b0, 2);
      tx(0, "swffc",  32'hFFC,  32'h5A5A5A5A, 4'hF, 4'h0, 32'h0,        1'b0, 2);
      tx(0, "lwffe",  32'hFFE,  32'h0,        4'h0, 4'hF, 32'h0,        1'b1, 2);
      tx(0, "swffe",  32'hFFE,  32'hFFFFFFFF, 4'hF, 4'h0, 32'h0,        1'b1, 2);
      tx(0, "lwffc",  32'hFFC,  32'h0,        4'h0, 4'hF, 32'h5A5A5A5A, 1'b0, 2);
      tx(0, "lbfff",  32'hFFF,  32'h0,        4'h0, 4'h1, 32'h0000005A, 1'b0, 2);
      tx(0, "sw1000", 32'h1000, 32'h12345678, 4'hF, 4'h0, 32'h0,        1'b1, 2);
      tx(0, "lw0",    32'h0,    32'h0,        4'h0, 4'hF, 32'hCAFEF00D, 1'b0, 2);
      tx(0, "rm0101", 32'h10,   32'h0,        4'h0, 4'h5, 32'h0,        1'b1, 2);
      tx(0, "both",   32'h10,   32'h99999999, 4'hF, 4'hF, 32'h0,        1'b1, 2);
      tx(0, "lw10d",  32'h10,   32'h0,        4'h0, 4'hF, 32'hA5223344, 1'b0, 2);
      tx(0, "empty",  32'h10,   32'hFFFFFFFF, 4'h0, 4'h0, 32'h0,        1'b0, 2);

      // Three wait states, base 0x100, 16 words
      tx(1, "sw104",  32'h104, 32'h01020304, 4'hF, 4'h0, 32'h0,        1'b0, 5);
      tx(1, "lw104",  32'h104, 32'h0,        4'h0, 4'hF, 32'h01020304, 1'b0, 5);
      tx(1, "lbff",   32'hFF,  32'h0,        4'h0, 4'h1, 32'h0,        1'b1, 5);
      tx(1, "lh13f",  32'h13F, 32'h0,        4'h0, 4'h3, 32'h0,        1'b1, 5);
      tx(1, "lh106",  32'h106, 32'h0,        4'h0, 4'h3, 32'h00000102, 1'b0, 5);
      tx(1, "sw108",  32'h108, 32'h11110000, 4'hF, 4'h0, 32'h0,        1'b0, 5);

      // Withdraw a store while it sits in WAIT
      addr = 32'h108; wdata = 32'hDDDDDDDD; wstrb = 4'hF; v3 = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      v3 = 1'b0; wstrb = 4'h0;
      pulses = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (rdy3) pulses++;
      end
      chk("wd_noready", pulses, 0);
      tx(1, "sw10c",  32'h10C, 32'h77777777, 4'hF, 4'h0, 32'h0,        1'b0, 5);
      tx(1, "lw10c",  32'h10C, 32'h0,        4'h0, 4'hF, 32'h77777777, 1'b0, 5);
      tx(1, "lw108",  32'h108, 32'h0,        4'h0, 4'hF, 32'h11110000, 1'b0, 5);

      // Reset during ACC0 of a crossing store
      tx(0, "sw20",   32'h20, 32'h11111111, 4'hF, 4'h0, 32'h0, 1'b0, 2);
      tx(0, "sw24",   32'h24, 32'h22222222, 4'hF, 4'h0, 32'h0, 1'b0, 2);
      addr = 32'h22; wdata = 32'hAABBCCDD; wstrb = 4'hF; v0 = 1'b1;
      @(posedge clk); #1;
      chk("mid_acc0", 32'(u_dut.state_q), 32'(ACC0));
      resetn = 1'b0;
      @(posedge clk); #1;
      v0 = 1'b0; wstrb = 4'h0;
      chk("mid_state", 32'(u_dut.state_q), 32'(IDLE));
      chk("mid_ready", 32'(rdy0), 32'd0);
      chk("mid_fault", 32'(flt0), 32'd0);
      chk("mid_rdata", rd0, 32'h0);
      resetn = 1'b1;
      @(posedge clk); #1;
      tx(0, "lw24",   32'h24, 32'h0, 4'h0, 4'hF, 32'h22222222, 1'b0, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/minrv32_dmem_responder.md
# minrv32_dmem_responder

Memory-side responder for the minrv32 data port. Accepts the core's `mem_*` load/store requests, steers byte lanes between the core's LSB-justified data and a word-organised, byte-enabled synchronous RAM, and splits accesses that cross a word boundary into two RAM cycles. It returns `mem_ready`, `mem_rdata` and a fault flag to the core wrapper, which holds the PC and request stable until ready.

## Interface
- `ADDR_BASE`, 32'h0000_0000: byte address of RAM word 0; must be 4-byte aligned.
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two, at least 2.
- `WAIT_STATES`, 0: extra stall cycles inserted before the first RAM access; 0..15.

Ports:
- `clk`  in  1  sole clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `mem_valid`  in  1  request present; held with stable fields until `mem_ready`.
- `mem_instr`  in  1  ignored; instruction fetch is not served here.
- `mem_addr`  in  32  byte address of the first byte.
- `mem_wdata`  in  32  store data, LSB-justified: byte i is stored at `mem_addr+i`.
- `mem_wstrb`  in  4  4'b0001, 4'b0011 or 4'b1111 for SB, SH and SW; 0 for loads.
- `mem_rmask`  in  4  same encodings for loads; 0 for stores.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  32  load data, LSB-justified; valid only while `mem_ready` is high.
- `mem_fault`  out  1  qualifies `mem_ready`: the access was rejected.

## Operation
- **Access size.** n = 1, 2 or 4 bytes, decoded from whichever of `wstrb` or `rmask` is non-zero. o = `mem_addr[1:0]`.
- **Fault conditions.** Any of the following sets `fault`:
  - the mask pattern is not one of the three legal encodings;
  - `wstrb` and `rmask` are both non-zero;
  - any of the n bytes lies outside [ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS).
- **Fault behaviour.** A faulting access performs no RAM write. It completes with `mem_fault`=1 and `mem_rdata`=0.
- **Empty request.** Both masks zero: completes normally with rdata 0 and no RAM access.
- **Crossing.** An access crosses a word boundary when o+n>4.
  - First word: lanes o..3.
  - Second word: lanes 0..(o+n-5) of the next word index.
- **Write steering.**
  - Core byte i goes to RAM word (addr+i)>>2, lane (o+i)&3.
  - The per-word strobe is the set of lanes touched in that word.
- **Read steering.**
  - `mem_rdata` byte i (i<n) is taken from the same location as in write steering.
  - Bytes i≥n are 0; the core sign/zero-extends.
  - For crossing loads, the first-word bytes are held in a 24-bit holding register.
- **FSM states.** IDLE, WAIT, ACC0, ACC1, RESP.
  - IDLE: when `mem_valid`, capture address, mask, wdata and the decoded fault/cross/n. Go to WAIT if `WAIT_STATES`>0, else ACC0.
  - WAIT: count `WAIT_STATES` cycles, then go to ACC0.
  - ACC0: issue the RAM access for word 0 (write strobes suppressed on fault or empty). Go to ACC1 if crossing and not faulting, else RESP.
  - ACC1: issue the access for word 1, then go to RESP.
  - RESP: `mem_ready`=1 for exactly one cycle; assemble rdata from the RAM output and holding register. Return to IDLE.
  - IDLE never accepts in the cycle immediately after RESP.
- **Request withdrawn.** `mem_valid` low in WAIT, ACC0 or ACC1 returns the FSM to IDLE next cycle.
  - Word writes already issued stay committed.
  - Unissued writes are dropped.
  - No `mem_ready` pulse is generated.
- **Reset.** While `resetn` is low at a clock edge: state IDLE, wait counter 0, `mem_ready`=0, `mem_rdata`=0, `mem_fault`=0, holding register 0. RAM contents are not cleared.

## Timing
- Captured fields drive all later states; input changes while busy are ignored, except `mem_valid` dropping.
- The RAM has a 1-cycle synchronous read. Word-0 data is available in ACC1 or RESP; word-1 data is available in RESP.
- Latency from the capture cycle (cycle 0) to the `mem_ready` cycle:
  - aligned, empty or faulting: 2+W cycles;
  - crossing: 3+W cycles;
  - where W = `WAIT_STATES`.
- Throughput: back-to-back requests have a minimum spacing of latency+1 cycles.
- `mem_ready`, `mem_fault` and `mem_rdata` are registered outputs; no combinational path from inputs.

## Structure
- **Shared package `minrv32_pkg`:**
  - state enum (IDLE, WAIT, ACC0, ACC1, RESP);
  - mask constants `MASK_B`=4'b0001, `MASK_H`=4'b0011, `MASK_W`=4'b1111;
  - `size_from_mask` function returning n (0 for an illegal pattern).
- **Sub-module `minrv32_bytemem`:** single-port word RAM with 4 per-byte write enables and 1-cycle synchronous read; parameter `DEPTH_WORDS`. The responder instantiates one and keeps all lane steering itself.

## Test plan
- **Aligned word, W=0:** SW addr 0x10, wdata 0xDEADBEEF, then LW 0x10 → each gets `mem_ready` at cycle 2; LW rdata 0xDEADBEEF, fault 0.
- **Byte lane steer:** SB addr 0x13, wdata 0x000000A5 over word 0x10 = 0x11223344; LBU 0x13 → rdata 0x000000A5, and word 0x10 reads 0xA5223344.
- **Crossing:**
  - SW 0x16 with 0x87654321: word 0x14 lanes 2,3 = 0x21,0x43; word 0x18 lanes 0,1 = 0x65,0x87.
  - LW 0x16 → 0x87654321, ready at cycle 3.
  - LH 0x17 → rdata 0x00006543.
- **Faults:**
  - LW at ADDR_BASE+4*DEPTH_WORDS-2 → ready with fault 1, rdata 0, no write.
  - rmask 4'b0101 → fault.
  - SW out of range → RAM unchanged.
- **Wait states and withdrawal:**
  - W=3: LW ready at cycle 5.
  - Drop `mem_valid` in WAIT → no ready; a following SW still completes.
- **Reset mid-access:** assert `resetn` low during ACC0 of a crossing SW → outputs 0, FSM in IDLE; word 0 may be written, word 1 untouched; the next request completes normally.
